pipe_stage_ctrl: RTL and testbench

- Sequencer directly downstream of the hazard detection unit. Consumes its registered hazard_stall / hazard_flush and turns them into per-stage enable, flush and bubble strobes plus a PC redirect.
- Converts one-cycle hazard indications into multi-cycle stall/flush windows.
- Holds everything on an external memory-not-ready stall.
- Keeps saturating stall/flush performance counters.

---
 rtl/pipe_stage_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_ctrl.sv
// Pipeline stage sequencer: expands registered hazard indications into
// stall/flush windows, per-stage strobes, a PC redirect and perf counters.
module pipe_stage_ctrl #(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned STALL_EX_CYCLES  = 1,
    parameter int unsigned STALL_MEM_CYCLES = 2,
    parameter int unsigned FLUSH_CYCLES     = 2,
    parameter int unsigned CNT_W            = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       hazard_stall,
    input  logic             hazard_flush,
    input  logic [XLEN-1:0]  branch_target,
    input  logic             ext_stall,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_bubble,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycle_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned MAX_A = (STALL_EX_CYCLES > STALL_MEM_CYCLES) ? STALL_EX_CYCLES
                                                                         : STALL_MEM_CYCLES;
    localparam int unsigned MAX_WIN = (MAX_A > FLUSH_CYCLES) ? MAX_A : FLUSH_CYCLES;
    localparam int unsigned WIN_W   = $clog2(MAX_WIN + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIN_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [XLEN-1:0]  ptgt_q, ptgt_d;
    logic [XLEN-1:0]  rpc_q, rpc_d;
    logic             rv_q, rv_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;

    logic             flush_req;
    logic [XLEN-1:0]  flush_tgt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            ptgt_q  <= '0;
            rpc_q   <= '0;
            rv_q    <= 1'b0;
            scnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ptgt_q  <= ptgt_d;
            rpc_q   <= rpc_d;
            rv_q    <= rv_d;
            scnt_q  <= scnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // A flush captured while frozen is replayed on the first unfrozen edge.
    assign flush_req = hazard_flush | pend_q;
    assign flush_tgt = hazard_flush ? branch_target : ptgt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ptgt_d  = ptgt_q;
        rpc_d   = rpc_q;
        rv_d    = rv_q;
        scnt_d  = scnt_q;
        fcnt_d  = fcnt_q;

        if (ext_stall) begin
            if (hazard_flush) begin
                pend_d = 1'b1;
                ptgt_d = branch_target;
            end
        end else begin
            rv_d = 1'b0;
            if (flush_req) begin
                state_d = ST_FLUSH;
                cnt_d   = WIN_W'(FLUSH_CYCLES - 1);
                rpc_d   = flush_tgt;
                pend_d  = 1'b0;
                rv_d    = 1'b1;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (hazard_stall == 2'b01) begin
                            state_d = ST_STALL;
                            cnt_d   = WIN_W'(STALL_EX_CYCLES - 1);
                        end else if (hazard_stall[1]) begin
                            state_d = ST_STALL;
                            cnt_d   = WIN_W'(STALL_MEM_CYCLES - 1);
                        end
                    end
                    ST_STALL, ST_FLUSH: begin
                        if (cnt_q == '0) begin
                            state_d = ST_RUN;
                        end else begin
                            cnt_d = cnt_q - WIN_W'(1);
                        end
                    end
                    default: state_d = ST_RUN;
                endcase
            end

            if (state_q == ST_STALL && scnt_q != {CNT_W{1'b1}}) begin
                scnt_d = scnt_q + CNT_W'(1);
            end
            if (rv_q && fcnt_q != {CNT_W{1'b1}}) begin
                fcnt_d = fcnt_q + CNT_W'(1);
            end
        end
    end

    // Stage strobe decode of the registered state, overridden by ext_stall.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_bubble = 1'b0;
        if (ext_stall) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
        end else begin
            case (state_q)
                ST_STALL: begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_bubble = 1'b1;
                end
                ST_FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign redirect_valid  = rv_q & ~ext_stall;
    assign redirect_pc     = rpc_q;
    assign ctrl_state      = state_q;
    assign stall_cycle_cnt = scnt_q;
    assign flush_cnt       = fcnt_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl using a per-cycle expectation queue.
module tb_pipe_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  hazard_stall;
    logic        hazard_flush;
    logic [31:0] branch_target;
    logic        ext_stall;

    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_cycle_cnt, flush_cnt;

    logic        pc_en4, if_id_en4, if_id_flush4, id_ex_en4, id_ex_bubble4, redirect_valid4;
    logic [31:0] redirect_pc4;
    logic [1:0]  ctrl_state4;
    logic [3:0]  stall_cycle_cnt4, flush_cnt4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_ctrl dut (
        .clk(clk), .reset_n(reset_n), .hazard_stall(hazard_stall), .hazard_flush(hazard_flush),
        .branch_target(branch_target), .ext_stall(ext_stall), .pc_en(pc_en), .if_id_en(if_id_en),
        .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .ctrl_state(ctrl_state),
        .stall_cycle_cnt(stall_cycle_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .hazard_stall(hazard_stall), .hazard_flush(hazard_flush),
        .branch_target(branch_target), .ext_stall(ext_stall), .pc_en(pc_en4), .if_id_en(if_id_en4),
        .if_id_flush(if_id_flush4), .id_ex_en(id_ex_en4), .id_ex_bubble(id_ex_bubble4),
        .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4), .ctrl_state(ctrl_state4),
        .stall_cycle_cnt(stall_cycle_cnt4), .flush_cnt(flush_cnt4)
    );

    typedef struct packed {
        logic [1:0]  hs;
        logic        hf;
        logic [31:0] bt;
        logic        es;
    } stim_t;

    typedef struct packed {
        logic [1:0]  st;
        logic [4:0]  en;   // pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] sc;
        logic [31:0] fc;
    } obs_t;

    localparam logic [1:0] RUN = 2'b00, STL = 2'b01, FLS = 2'b10;
    localparam logic [4:0] EN_RUN = 5'b11010, EN_STL = 5'b00011, EN_FLS = 5'b11111, EN_X = 5'b00000;

    stim_t sq[$];
    obs_t  eq[$];
    stim_t s;
    obs_t  o, e;

    function automatic stim_t S(logic [1:0] hs, logic hf, logic [31:0] bt, logic es);
        S = '{hs: hs, hf: hf, bt: bt, es: es};
    endfunction

    function automatic obs_t E(logic [1:0] st, logic [4:0] en, logic rv, logic [31:0] rpc,
                               logic [31:0] sc, logic [31:0] fc);
        E = '{st: st, en: en, rv: rv, rpc: rpc, sc: sc, fc: fc};
    endfunction

    function automatic obs_t observe();
        observe = '{st: ctrl_state, en: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble},
                    rv: redirect_valid, rpc: redirect_pc, sc: stall_cycle_cnt, fc: flush_cnt};
    endfunction

    function automatic string fmt(obs_t v);
        fmt = $sformatf("st=%b en=%b rv=%b pc=%h sc=%0d fc=%0d", v.st, v.en, v.rv, v.rpc, v.sc, v.fc);
    endfunction

    task automatic row(stim_t st, obs_t ex);
        sq.push_back(st);
        eq.push_back(ex);
    endtask

    task automatic apply(stim_t st);
        hazard_stall  = st.hs;
        hazard_flush  = st.hf;
        branch_target = st.bt;
        ext_stall     = st.es;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        apply(S(2'b00, 1'b0, 32'h0, 1'b0));
        @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        apply(S(2'b00, 1'b0, 32'h0, 1'b0));
        @(negedge clk);
        o = observe();
        checks++;
        if (o !== E(RUN, EN_RUN, 1'b0, 32'h0, 32'd0, 32'd0)) begin
            failures++;
            $display("FAIL reset_hold: got %s", fmt(o));
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) row(S(2'b00, 1'b0, 32'h0, 1'b0), E(RUN, EN_RUN, 1'b0, 32'h0, 32'd0, 32'd0));
        for (int r = 0; sq.size() != 0; r++) begin
            s = sq.pop_front(); e = eq.pop_front();
            apply(s);
            @(negedge clk);
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_idle row%0d: got %s want %s", r, fmt(o), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        do_reset();
        row(S(2'b10, 0, 0, 0), E(RUN, EN_RUN, 0, 0, 0, 0));
        row(S(2'b00, 0, 0, 0), E(STL, EN_STL, 0, 0, 0, 0));
        row(S(2'b00, 0, 0, 0), E(STL, EN_STL, 0, 0, 1, 0));
        row(S(2'b00, 0, 0, 0), E(RUN, EN_RUN, 0, 0, 2, 0));
        row(S(2'b01, 0, 0, 0), E(RUN, EN_RUN, 0, 0, 2, 0));
        row(S(2'b00, 0, 0, 0), E(STL, EN_STL, 0, 0, 2, 0));
        row(S(2'b11, 0, 0, 0), E(RUN, EN_RUN, 0, 0, 3, 0));
        row(S(2'b00, 0, 0, 0), E(STL, EN_STL, 0, 0, 3, 0));
        row(S(2'b01, 0, 0, 0), E(STL, EN_STL, 0, 0, 4, 0));
        row(S(2'b00, 0, 0, 0), E(RUN, EN_RUN, 0, 0, 5, 0));
        row(S(2'b00, 0, 0, 0), E(RUN, EN_RUN, 0, 0, 5, 0));
        for (int r = 0; sq.size() != 0; r++) begin
            s = sq.pop_front(); e = eq.pop_front();
            apply(s);
            @(negedge clk);
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL stall row%0d: got %s want %s", r, fmt(o), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        do_reset();
        row(S(2'b00, 1, 32'h1000, 0), E(RUN, EN_RUN, 0, 32'h0,    0, 0));
        row(S(2'b00, 0, 0, 0),        E(FLS, EN_FLS, 1, 32'h1000, 0, 0));
        row(S(2'b00, 0, 0, 0),        E(FLS, EN_FLS, 0, 32'h1000, 0, 1));
        row(S(2'b00, 1, 32'h1100, 0), E(RUN, EN_RUN, 0, 32'h1000, 0, 1));
        row(S(2'b00, 0, 0, 0),        E(FLS, EN_FLS, 1, 32'h1100, 0, 1));
        row(S(2'b00, 1, 32'h1200, 0), E(FLS, EN_FLS, 0, 32'h1100, 0, 2));
        row(S(2'b10, 0, 0, 0),        E(FLS, EN_FLS, 1, 32'h1200, 0, 2));
        row(S(2'b00, 0, 0, 0),        E(FLS, EN_FLS, 0, 32'h1200, 0, 3));
        row(S(2'b10, 0, 0, 0),        E(RUN, EN_RUN, 0, 32'h1200, 0, 3));
        row(S(2'b00, 1, 32'h1300, 0), E(STL, EN_STL, 0, 32'h1200, 0, 3));
        row(S(2'b00, 0, 0, 0),        E(FLS, EN_FLS, 1, 32'h1300, 1, 3));
        row(S(2'b00, 0, 0, 0),        E(FLS, EN_FLS, 0, 32'h1300, 1, 4));
        row(S(2'b00, 0, 0, 0),        E(RUN, EN_RUN, 0, 32'h1300, 1, 4));
        for (int r = 0; sq.size() != 0; r++) begin
            s = sq.pop_front(); e = eq.pop_front();
            apply(s);
            @(negedge clk);
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL flush row%0d: got %s want %s", r, fmt(o), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush_priority();
        do_reset();
        row(S(2'b01, 1, 32'h1400, 0), E(RUN, EN_RUN, 0, 32'h0,    0, 0));
        row(S(2'b00, 0, 0, 0),        E(FLS, EN_FLS, 1, 32'h1400, 0, 0));
        row(S(2'b00, 0, 0, 0),        E(FLS, EN_FLS, 0, 32'h1400, 0, 1));
        row(S(2'b00, 0, 0, 0),        E(RUN, EN_RUN, 0, 32'h1400, 0, 1));
        for (int r = 0; sq.size() != 0; r++) begin
            s = sq.pop_front(); e = eq.pop_front();
            apply(s);
            @(negedge clk);
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL flush_priority row%0d: got %s want %s", r, fmt(o), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ext_stall();
        do_reset();
        row(S(2'b00, 0, 0, 1),        E(RUN, EN_X,   0, 32'h0,    0, 0));
        row(S(2'b10, 1, 32'h1F00, 1), E(RUN, EN_X,   0, 32'h0,    0, 0));
        row(S(2'b00, 1, 32'h2000, 1), E(RUN, EN_X,   0, 32'h0,    0, 0));
        row(S(2'b00, 0, 0, 0),        E(RUN, EN_RUN, 0, 32'h0,    0, 0));
        row(S(2'b00, 0, 0, 0),        E(FLS, EN_FLS, 1, 32'h2000, 0, 0));
        row(S(2'b00, 0, 0, 0),        E(FLS, EN_FLS, 0, 32'h2000, 0, 1));
        row(S(2'b00, 1, 32'h2100, 0), E(RUN, EN_RUN, 0, 32'h2000, 0, 1));
        row(S(2'b00, 0, 0, 1),        E(FLS, EN_X,   0, 32'h2100, 0, 1));
        row(S(2'b00, 0, 0, 1),        E(FLS, EN_X,   0, 32'h2100, 0, 1));
        row(S(2'b00, 0, 0, 0),        E(FLS, EN_FLS, 1, 32'h2100, 0, 1));
        row(S(2'b00, 0, 0, 0),        E(FLS, EN_FLS, 0, 32'h2100, 0, 2));
        row(S(2'b10, 0, 0, 0),        E(RUN, EN_RUN, 0, 32'h2100, 0, 2));
        row(S(2'b00, 0, 0, 1),        E(STL, EN_X,   0, 32'h2100, 0, 2));
        row(S(2'b00, 0, 0, 0),        E(STL, EN_STL, 0, 32'h2100, 0, 2));
        row(S(2'b00, 0, 0, 0),        E(STL, EN_STL, 0, 32'h2100, 1, 2));
        row(S(2'b00, 0, 0, 0),        E(RUN, EN_RUN, 0, 32'h2100, 2, 2));
        for (int r = 0; sq.size() != 0; r++) begin
            s = sq.pop_front(); e = eq.pop_front();
            apply(s);
            @(negedge clk);
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL ext_stall row%0d: got %s want %s", r, fmt(o), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int sc;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            sc = (i / 3) * 2 + ((i % 3 == 2) ? 1 : 0);
            row(S(2'b10, 0, 0, 0), E((i % 3 == 0) ? RUN : STL, (i % 3 == 0) ? EN_RUN : EN_STL,
                                     0, 32'h0, 32'(sc), 32'd0));
        end
        for (int r = 0; sq.size() != 0; r++) begin
            s = sq.pop_front(); e = eq.pop_front();
            apply(s);
            @(negedge clk);
            o = observe();
            checks++;
            if (o !== e || stall_cycle_cnt4 !== ((e.sc > 15) ? 4'hF : e.sc[3:0]) || flush_cnt4 !== 4'h0) begin
                failures++;
                $display("FAIL back_to_back row%0d: got %s sc4=%0d fc4=%0d want %s sc4<=15",
                         r, fmt(o), stall_cycle_cnt4, flush_cnt4, fmt(e));
            end
            @(posedge clk); #1;
        end
        apply(S(2'b00, 1, 32'h3000, 0));
        @(posedge clk); #1;
        apply(S(2'b00, 0, 0, 0));
        checks++;
        if (ctrl_state !== FLS || stall_cycle_cnt4 !== 4'hF) begin
            failures++;
            $display("FAIL pre_reset_flush: got st=%b sc4=%0d want st=10 sc4=15", ctrl_state, stall_cycle_cnt4);
        end
        reset_n = 1'b0;
        @(negedge clk);
        o = observe();
        checks++;
        if (o !== E(RUN, EN_RUN, 0, 32'h0, 0, 0) || stall_cycle_cnt4 !== 4'h0 || flush_cnt4 !== 4'h0
            || ctrl_state4 !== RUN) begin
            failures++;
            $display("FAIL mid_flush_reset: got %s sc4=%0d fc4=%0d st4=%b want all reset",
                     fmt(o), stall_cycle_cnt4, flush_cnt4, ctrl_state4);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_flush();
        test_flush_priority();
        test_ext_stall();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
